// File: rtl/store_buffer_if.sv
// Bundle of the store-buffer request, forwarding and data-memory signals.
// master = pipeline/memory side, slave = the store buffer itself.
interface store_buffer_if #(
    parameter int CW = 3
);
    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          ld_hit;
    logic [31:0]   ld_data;
    logic          stall;
    logic          sb_empty;
    logic [CW-1:0] count;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_data_in;
    logic          dm_MemWrite;
    logic          dm_MemRead;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_hit, ld_data, stall, sb_empty, count,
        input  dm_addr, dm_data_in, dm_MemWrite, dm_MemRead
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_hit, ld_data, stall, sb_empty, count,
        output dm_addr, dm_data_in, dm_MemWrite, dm_MemRead
    );
endinterface

// File: rtl/store_buffer.sv
// MEM-stage store buffer: circular FIFO of stores drained to dm, with youngest-match load forwarding.
// Optional SB_BYPASS_EN: a store into an empty buffer with a free dm port is written to dm directly.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    store_buffer_if.slave sb
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_st_ready;
    logic          w_hit;
    logic [31:0]   w_fwd_data;
    logic          w_ld_miss;
    logic          w_pop;
    logic          w_push;
    logic          w_bypass;

    // Walk oldest to youngest so the last match seen is the youngest store.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        logic [AW-1:0] idx;
        w_hit      = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + AW'(i);
            if ((CW'(i) < r_count) && (r_addr[idx] == sb.ld_addr)) begin
                w_hit      = 1'b1;
                w_fwd_data = r_data[idx];
            end
        end
    end

    always_comb begin
        w_st_ready = (r_count != CW'(DEPTH));
        w_ld_miss  = sb.ld_valid && !w_hit;
        w_pop      = !w_ld_miss && (r_count != '0);
`ifdef SB_BYPASS_EN
        w_bypass   = reset && sb.st_valid && (r_count == '0) && !w_ld_miss;
`else
        w_bypass   = 1'b0;
`endif
        w_push     = sb.st_valid && w_st_ready && !w_bypass;
    end

    // dm port: a missing load wins, then the head entry, then a bypassed store.
    always_comb begin
        sb.dm_addr     = '0;
        sb.dm_data_in  = '0;
        sb.dm_MemWrite = 1'b0;
        sb.dm_MemRead  = 1'b0;
        if (w_ld_miss) begin
            sb.dm_addr    = sb.ld_addr;
            sb.dm_MemRead = 1'b1;
        end else if (w_pop) begin
            sb.dm_addr     = r_addr[r_head];
            sb.dm_data_in  = r_data[r_head];
            sb.dm_MemWrite = 1'b1;
        end else if (w_bypass) begin
            sb.dm_addr     = sb.st_addr;
            sb.dm_data_in  = sb.st_data;
            sb.dm_MemWrite = 1'b1;
        end
    end

    assign sb.st_ready = w_st_ready;
    assign sb.stall    = sb.st_valid && !w_st_ready;
    assign sb.ld_hit   = w_hit;
    assign sb.ld_data  = w_fwd_data;
    assign sb.sb_empty = (r_count == '0);
    assign sb.count    = r_count;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_pop)  r_head <= r_head + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: entry storage is deliberately not reset; r_count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= sb.st_addr;
            r_data[r_tail] <= sb.st_data;
        end
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- MEM-stage write buffer between the EX/MEM pipeline register and the data memory (dm). Queues stores and retires them to dm one per cycle whenever dm's single address port is free.
- Loads are checked against queued stores. The youngest matching store forwards its data; otherwise the load goes to dm.
- Decouples store retirement from loads; asserts stall only on overflow.

Parameters:
- DEPTH, 4, number of store entries; power of two, >= 2
- CW, 3, width of count output = $clog2(DEPTH)+1

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-low; clears buffer when 0 at posedge clk
- st_valid  in  1  store request from EX/MEM
- st_addr  in  32  store word address, as indexed by dm
- st_data  in  32  store data
- st_ready  out  1  buffer can accept a store (= count != DEPTH)
- ld_valid  in  1  load request from EX/MEM
- ld_addr  in  32  load word address
- ld_hit  out  1  combinational; load matches a buffered entry
- ld_data  out  32  combinational forwarded data; 0 when !ld_hit
- stall  out  1  st_valid && !st_ready; upstream holds its store
- sb_empty  out  1  count == 0; used for fence/halt
- count  out  CW  number of valid entries
- dm_addr  out  32  to dm addr
- dm_data_in  out  32  to dm data_in
- dm_MemWrite  out  1  to dm MemWrite
- dm_MemRead  out  1  to dm MemRead

Behaviour:
- Storage: circular FIFO of DEPTH {addr, data} entries with head ptr, tail ptr and count.
  - Pointers wrap modulo DEPTH.
  - Ordering from head (oldest) to tail (youngest).
- Reset: at posedge with reset==0, set ptrs=0 and count=0; pending stores are discarded. Resulting outputs:
  - st_ready=1, sb_empty=1, count=0
  - dm_MemWrite=0, dm_MemRead=0, stall=0
  - ld_hit=0, ld_data=0
  - dm_addr=0, dm_data_in=0
- Forwarding (combinational):
  - Compare ld_addr, full 32 bits, against every valid entry.
  - ld_hit=1 if any match; ld_data = data of the youngest matching entry.
  - A store presented in the same cycle is not visible to a load in that cycle; the load is treated as older.
- dm port arbitration (combinational, every cycle):
  - ld_valid && !ld_hit: dm_addr=ld_addr, dm_MemRead=1, dm_MemWrite=0, no pop. dm returns load data at negedge.
  - Otherwise, if count>0: dm_addr=head.addr, dm_data_in=head.data, dm_MemWrite=1, dm_MemRead=0. dm writes at the negedge of this cycle; head pops at the following posedge.
  - Otherwise: dm_MemWrite=0, dm_MemRead=0, dm_addr=0, dm_data_in=0.
  - Drain rate is at most 1 entry per cycle. The latency of a store into an empty buffer is: push at posedge N, written to dm at the negedge of cycle N+1.
- Push: at posedge, if st_valid && st_ready, write entry at tail and advance tail.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full:
  - st_ready=0 even if a pop occurs that same cycle; there is no full-bypass.
  - stall=1 while st_valid; the store is not captured.
- Empty: no pop, ld_hit=0.
- Both st_valid and ld_valid asserted in one cycle is legal; each is handled independently per the rules above.
- Count never exceeds DEPTH and never underflows; a pop is only issued when count>0.

Optional Feature:
- Macro SB_BYPASS_EN. When defined: if count==0, st_valid=1, and not (ld_valid && !ld_hit), the store is written to dm directly that cycle and is not enqueued.
  - Direct write drives dm_addr=st_addr, dm_data_in=st_data, dm_MemWrite=1.
  - Count stays 0 and latency drops by one cycle.
- When undefined: every store is enqueued per the Push rule.

Test Plan:
- Reset: hold reset=0 for 2 cycles with st_valid=1 -> count=0, sb_empty=1, st_ready=1, dm_MemWrite=0, stall=0.
- Fill/overflow: hold ld_valid=1 with ld_addr=0x3FF (miss, so drain is blocked). Store 0x10..0x13 with data 0x11111111..0x44444444, then a 5th store -> count=4, stall=1, st_ready=0, 5th store not captured. Drop ld_valid -> dm_MemWrite=1 for 4 consecutive cycles, dm_addr 0x10,0x11,0x12,0x13 in order, then sb_empty=1.
- Youngest-match forwarding: with drain blocked, store 0x20=0xAAAA0000, then 0x20=0xBBBB0000; load 0x20 -> ld_hit=1, ld_data=0xBBBB0000, dm_MemRead=0, and head drains that cycle.
- Load miss priority: with count=2, load 0x30 -> dm_addr=0x30, dm_MemRead=1, dm_MemWrite=0, count stays 2.
- Reset mid-operation: with count=3, pulse reset=0 for one cycle -> next cycle count=0, sb_empty=1, dm_MemWrite=0; the 3 stores never reach dm.
- Bypass, run with SB_BYPASS_EN defined and then undefined: empty buffer, single store 0x40=0xCAFEF00D.
  - Defined: dm_MemWrite=1 in the same cycle with dm_addr=0x40, count stays 0.
  - Undefined: count=1 the next cycle, write occurs in that cycle.
